// File: rtl/inst_queue_if.sv
// Handshake bundle between fetch (producer), the instruction queue and the
// decode/issue stage (consumer).
//   push_valid/push_inst/push_pc : fetch -> queue, one instruction per cycle
//   stall_out                    : queue -> fetch, almost-full back-pressure
//   pop_valid/pop_inst/pop_pc    : queue -> consumer, head entry (fall-through)
//   pop_ready                    : consumer -> queue, head accepted this cycle
// master = fetch/consumer side, slave = the queue.
interface inst_queue_if #(
  parameter int XLEN = 32
);
  logic            push_valid;
  logic [XLEN-1:0] push_inst;
  logic [XLEN-1:0] push_pc;
  logic            stall_out;
  logic            pop_valid;
  logic            pop_ready;
  logic [XLEN-1:0] pop_inst;
  logic [XLEN-1:0] pop_pc;

  modport master (
    output push_valid, push_inst, push_pc, pop_ready,
    input  stall_out, pop_valid, pop_inst, pop_pc
  );

  modport slave (
    input  push_valid, push_inst, push_pc, pop_ready,
    output stall_out, pop_valid, pop_inst, pop_pc
  );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode/issue: a circular buffer of
// 2^DEPTH_LOG2 {inst, pc} entries with first-word fall-through on the pop side.
// Ports:
//   clk_in       : system clock, rising edge
//   rst_in       : asynchronous active-low reset (release synchronised upstream)
//   rdy_in       : global ready; low freezes all state
//   flush_in     : redirect; empties the queue at the edge (when rdy_in high)
//   q_if         : push/pop handshake bundle (slave side)
//   count_out    : occupied entries, 0..DEPTH
//   overflow_out : sticky, set when a push had to be dropped
module inst_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int XLEN       = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  inst_queue_if.slave           q_if,
  output logic [DEPTH_LOG2:0]   count_out,
  output logic                  overflow_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_HI   = CNT_FULL - CNT_ONE;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [XLEN-1:0]       mem_inst [DEPTH];
  logic [XLEN-1:0]       mem_pc   [DEPTH];
  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;

  logic pop_fire;
  logic push_acc;
  logic advance;

  // A full queue still takes a push when the head leaves in the same cycle.
  assign pop_fire = (count != '0) && q_if.pop_ready;
  assign push_acc = q_if.push_valid && ((count < CNT_FULL) || pop_fire);
  assign advance  = rdy_in && !flush_in;

  assign q_if.pop_valid = (count != '0);
  assign q_if.pop_inst  = mem_inst[head];
  assign q_if.pop_pc    = mem_pc[head];
  // Raised one entry early so fetch has a cycle to react.
  assign q_if.stall_out = (count >= CNT_HI);
  assign count_out      = count;
  assign overflow_out   = overflow;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (pop_fire) begin
          head <= head + PTR_ONE;
        end
        if (push_acc) begin
          tail <= tail + PTR_ONE;
        end
        if (q_if.push_valid && !push_acc) begin
          overflow <= 1'b1;
        end
        case ({push_acc, pop_fire})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage is not reset; contents are only observed while pop_valid.
  always_ff @(posedge clk_in) begin
    if (advance && push_acc) begin
      mem_inst[tail] <= q_if.push_inst;
      mem_pc[tail]   <= q_if.push_pc;
    end
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 4, giving log2 of the entry count; DEPTH = 2^DEPTH_LOG2 (16).
REQ-002 The block SHALL have parameter XLEN, default 32, giving the instruction and PC width.
REQ-003 clk_in  input  1  system clock, one clock domain; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low.
REQ-005 rdy_in  input  1  global ready; low freezes all state.
REQ-006 flush_in  input  1  pipeline redirect; discard all entries.
REQ-007 push_valid  input  1  fetch stage delivers one instruction this cycle.
REQ-008 push_inst  input  XLEN  fetched instruction word.
REQ-009 push_pc  input  XLEN  PC of push_inst.
REQ-010 stall_out  output  1  almost-full back-pressure to the fetch stage.
REQ-011 pop_valid  output  1  head entry is valid.
REQ-012 pop_ready  input  1  consumer (decode/issue) accepts head this cycle.
REQ-013 pop_inst  output  XLEN  head instruction.
REQ-014 pop_pc  output  XLEN  head PC.
REQ-015 count_out  output  DEPTH_LOG2+1  number of occupied entries, 0..DEPTH.
REQ-016 overflow_out  output  1  sticky flag: a push was dropped.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH entries {inst, pc} with head pointer, tail pointer (DEPTH_LOG2 bits each, wrap modulo DEPTH) and a count register.
REQ-018 Push accept SHALL be push_valid && (count < DEPTH || pop_fire); an accepted push writes entry[tail] and advances tail by 1.
REQ-019 pop_fire SHALL be pop_valid && pop_ready; pop_fire advances head by 1.
REQ-020 Simultaneous accepted push and pop_fire SHALL leave count unchanged, including at count == DEPTH and count == 1.
REQ-021 pop_valid SHALL equal (count != 0); pop_inst/pop_pc SHALL be entry[head] combinationally (first-word fall-through).
REQ-022 Push-to-pop latency SHALL be one cycle: an instruction pushed at edge N is presented on pop_* after edge N; no same-cycle bypass when empty.
REQ-023 pop_ready while count == 0 SHALL have no effect.
REQ-024 stall_out SHALL be combinational: asserted when count >= DEPTH-1, giving the fetch stage one cycle of slack.
REQ-025 A push_valid that is not accepted SHALL be dropped without changing entries, pointers or count, and SHALL set overflow_out, which stays high until reset.
REQ-026 flush_in high with rdy_in high SHALL, at that edge, set head = tail = 0 and count = 0; any same-cycle push or pop is discarded; overflow_out is unaffected.
REQ-027 pop_* outputs SHALL not be qualified by flush_in; pop_valid deasserts from the cycle after the flush edge.
REQ-028 rdy_in low SHALL freeze pointers, count, entries and overflow_out, ignoring push_valid, pop_ready and flush_in; combinational outputs keep reflecting the frozen state.
REQ-029 count_out SHALL equal the count register; count SHALL never exceed DEPTH or go below 0.

Reset
REQ-030 rst_in low SHALL immediately, without a clock edge, clear head, tail, count and overflow_out to 0; pop_valid = 0, stall_out = 0, count_out = 0.
REQ-031 Entry contents need not be reset; pop_inst/pop_pc are don't-care while pop_valid = 0.
REQ-032 Assertion of rst_in mid-operation SHALL abandon all entries; the first push after deassertion lands at index 0.
REQ-033 Release of rst_in SHALL be synchronised by the integrator; the block requires state to be stable from the first clock edge after release.

Verification
REQ-034 Reset, then push 0x00000013 @ pc 0x0 with pop_ready = 0 -> next cycle pop_valid = 1, pop_inst = 0x00000013, pop_pc = 0x0, count_out = 1.
REQ-035 Push 15 entries with no pops -> stall_out rises when count_out = 15; push a 16th -> count_out = 16; push a 17th -> dropped, overflow_out = 1, head unchanged.
REQ-036 At count_out = 16, push and pop in the same cycle -> count_out stays 16, the popped pc is the oldest, and the new entry is written at the wrapped tail index.
REQ-037 Fill 5 entries, then assert flush_in with push_valid = 1 and pop_ready = 1 -> count_out = 0 and pop_valid = 0 next cycle; the next push appears at pop_* after one cycle.
REQ-038 Hold rdy_in = 0 for 3 cycles while toggling push_valid, pop_ready and flush_in -> count_out and pop_pc are unchanged; on rdy_in = 1, normal operation resumes.
REQ-039 Assert rst_in (low) between clock edges with 8 entries -> count_out = 0 and pop_valid = 0 before the next edge; 20 push/pop cycles streaming across the pointer wrap -> pc order preserved.
